// File: rtl/enc42_pkg.sv
// Shared types and code constants for the 4-to-2 encoder with arbitration.
package enc42_pkg;

    localparam int unsigned CODE_W = 2;
    localparam int unsigned REQ_W  = 4;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [REQ_W-1:0]  req_t;

    localparam code_t C_Q0 = 2'b00;
    localparam code_t C_Q1 = 2'b01;
    localparam code_t C_Q2 = 2'b10;
    localparam code_t C_Q3 = 2'b11;

endpackage

// File: rtl/enc42_pick.sv
// Masked priority picker: first set request scanning from start, wrapping 3 to 0.
module enc42_pick
    import enc42_pkg::*;
(
    input  req_t  req,
    input  code_t start,
    output code_t win,
    output logic  any,
    output logic  multi
);

    code_t idx;
    logic  found;

    always_comb begin
        win   = C_Q0;
        idx   = C_Q0;
        found = 1'b0;
        for (int k = 0; k < int'(REQ_W); k++) begin
            idx = code_t'(start + code_t'(k));
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign any   = |req;
    // Clearing the lowest set bit leaves something only when two or more are set.
    assign multi = |(req & req_t'(req - req_t'(1)));

endmodule

// File: rtl/enc42_rr.sv
// Clocked 4-to-2 encoder with valid, multi-hot detect, round-robin/fixed arbitration and sticky error.
module enc42_rr
    import enc42_pkg::*;
#(
    parameter bit RR_EN     = 1'b1,
    parameter bit HOLD_LAST = 1'b1
) (
    input  logic       CLK,
    input  logic       RSTB,
    input  logic       EN,
    input  logic [3:0] D,
    input  logic       CLR,
    output logic       OUT1,
    output logic       OUT2,
    output logic       VLD,
    output logic       MULTI,
    output logic       ERR
);

    code_t code_q, code_d;
    code_t ptr_q, ptr_d;
    logic  vld_q, vld_d;
    logic  multi_q, multi_d;
    logic  err_q, err_d;

    code_t pick_start;
    code_t pick_win;
    logic  pick_any;
    logic  pick_multi;

    assign pick_start = RR_EN ? ptr_q : C_Q0;

    enc42_pick u_pick (
        .req   (req_t'(D)),
        .start (pick_start),
        .win   (pick_win),
        .any   (pick_any),
        .multi (pick_multi)
    );

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            code_q  <= C_Q0;
            ptr_q   <= C_Q0;
            vld_q   <= 1'b0;
            multi_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            code_q  <= code_d;
            ptr_q   <= ptr_d;
            vld_q   <= vld_d;
            multi_q <= multi_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        code_d  = code_q;
        ptr_d   = ptr_q;
        vld_d   = 1'b0;
        multi_d = 1'b0;
        if (EN) begin
            if (pick_any) begin
                code_d  = pick_win;
                vld_d   = 1'b1;
                multi_d = pick_multi;
                if (RR_EN) begin
                    ptr_d = code_t'(pick_win + code_t'(1));
                end
            end else if (!HOLD_LAST) begin
                code_d = C_Q0;
            end
        end
    end

    // A multi-hot sample beats a same-cycle clear.
    always_comb begin
        err_d = err_q;
        if (CLR) begin
            err_d = 1'b0;
        end
        if (EN && pick_multi) begin
            err_d = 1'b1;
        end
    end

    assign OUT1  = code_q[1];
    assign OUT2  = code_q[0];
    assign VLD   = vld_q;
    assign MULTI = multi_q;
    assign ERR   = err_q;

endmodule
